phy_tx_pattern_gen: RTL and testbench

- Synthesizable, parametrised stimulus source for the phy_rx lanes. Generalises the hand-written serial lane driving into a per-lane byte sequencer.
- On each start it sends NUM_COMMA comma bytes on every lane, then a programmable burst of data bytes, each serialised MSB-first at one bit per clk_8f.
- Used in benches and in loopback self-test in front of phy_rx.

---
 rtl/phy_pkg.sv | 24 ++
 rtl/phy_tx_pattern_gen_lane_serializer.sv | 38 +++
 rtl/phy_tx_pattern_gen.sv | 235 +++++++++++++++++++++++
 tb/tb_phy_tx_pattern_gen.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// Shared definitions for the phy_tx_pattern_gen slice.
// Contents:
//   COMMA_DEFAULT - default comma/sync symbol
//   mode_e        - data sequencing modes
//   state_e       - sequencer FSM states
package phy_pkg;

   localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

   typedef enum logic [1:0] {
      MODE_INC   = 2'd0,
      MODE_DEC   = 2'd1,
      MODE_HOLD  = 2'd2,
      MODE_COMMA = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/phy_tx_pattern_gen_lane_serializer.sv
// lane_serializer: WIDTH-bit parallel-load, MSB-first shift register.
// Ports:
//   clk_8f  bit clock          reset  synchronous, active-high
//   en      0 holds contents   load   parallel load from din
//   shift   shift left by one  clear  zero the register
//   din     parallel symbol    dout   current serial bit (MSB)
// Priority when en=1: clear > load > shift.
module lane_serializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk_8f,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic             shift,
   input  logic             clear,
   input  logic [WIDTH-1:0] din,
   output logic             dout
);

   logic [WIDTH-1:0] sr;

   always_ff @(posedge clk_8f) begin
      if (reset) begin
         sr <= '0;
      end else if (en) begin
         if (clear)
            sr <= '0;
         else if (load)
            sr <= din;
         else if (shift)
            sr <= sr << 1;
      end
   end

   assign dout = sr[WIDTH-1];

endmodule

// File: rtl/phy_tx_pattern_gen.sv
// phy_tx_pattern_gen: per-lane byte sequencer driving serial lanes.
// On start, NUM_COMMA comma symbols go out on every lane, followed by
// burst_len data symbols, each MSB-first at one bit per clk_8f.
// Ports:
//   clk_8f, reset (sync, active-high), enable (0 freezes everything)
//   start      level, sampled only in IDLE
//   mode       0 INC, 1 DEC, 2 HOLD, 3 COMMA_ONLY
//   seed       lane-0 first data byte (lane k starts at seed-k)
//   burst_len  data bytes per lane, latched at start
//   out        serial bit per lane
//   is_comma   symbol on out is a comma
//   byte_strobe last bit of every symbol
//   busy       SYNC/DATA in progress
//   done       one-cycle pulse after the last bit
// Optional build macro COMMA_INSERT_EN: inserts one comma after every GAP
// data bytes while more data remain; lane registers do not advance and
// the inserted commas do not count toward burst_len.
//
// state   | meaning
// --------+---------------------------------------------
// IDLE    | outputs low, waiting for enable && start
// SYNC    | shifting NUM_COMMA comma symbols
// DATA    | shifting burst_len data symbols
// DONE    | done pulse, back to IDLE next cycle
module phy_tx_pattern_gen
   import phy_pkg::*;
#(
   parameter int               LANES     = 2,
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] COMMA     = WIDTH'(COMMA_DEFAULT),
   parameter int               NUM_COMMA = 4,
   parameter logic [WIDTH-1:0] STEP      = WIDTH'(8'h11),
   parameter int               GAP       = 2
) (
   input  logic             clk_8f,
   input  logic             reset,
   input  logic             enable,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] seed,
   input  logic [7:0]       burst_len,
   output logic [LANES-1:0] out,
   output logic             is_comma,
   output logic             byte_strobe,
   output logic             busy,
   output logic             done
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   // What happens at the coming edge; shared by the FSM and the serializers
   // so both sides agree on symbol boundaries.
   typedef enum logic [2:0] {
      ACT_HOLD, ACT_START, ACT_SHIFT, ACT_COMMA,
      ACT_INS, ACT_DATA, ACT_END, ACT_FINISH
   } act_e;

   state_e           state;
   mode_e            mode_q;
   logic [7:0]       burst_q;
   logic [BW-1:0]    bit_cnt;   // bits left after the current one
   logic [7:0]       sym_cnt;   // symbols left after the current one
   logic             ins_q;     // current symbol is an inserted comma
   logic             done_r;
`ifdef COMMA_INSERT_EN
   logic [7:0]       gap_cnt;   // data bytes left in the current group
`endif

   logic [WIDTH-1:0] data_q   [LANES];
   logic [WIDTH-1:0] data_nxt [LANES];
   logic [WIDTH-1:0] lane_din [LANES];
   act_e             act;
   logic             adv;
   logic             ser_load, ser_shift, ser_clear;

   always_comb begin
      act = ACT_HOLD;
      if (enable) begin
         case (state)
            ST_IDLE: if (start) act = ACT_START;
            ST_SYNC: begin
               if (bit_cnt != '0)       act = ACT_SHIFT;
               else if (sym_cnt != '0)  act = ACT_COMMA;
               else if (burst_q != '0)  act = ACT_DATA;
               else                     act = ACT_END;
            end
            ST_DATA: begin
               if (bit_cnt != '0)       act = ACT_SHIFT;
               else if (ins_q)          act = ACT_DATA;
               else if (sym_cnt == '0)  act = ACT_END;
`ifdef COMMA_INSERT_EN
               else if (gap_cnt == '0)  act = ACT_INS;
`endif
               else                     act = ACT_DATA;
            end
            ST_DONE: act = ACT_FINISH;
            default: act = ACT_HOLD;
         endcase
      end
   end

   // Lane registers step on the last bit of every real data byte.
   assign adv = enable && (state == ST_DATA) && (bit_cnt == '0) && !ins_q;

   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         data_nxt[k] = data_q[k];
         if (adv) begin
            case (mode_q)
               MODE_INC: data_nxt[k] = data_q[k] + STEP;
               MODE_DEC: data_nxt[k] = data_q[k] - STEP;
               default:  data_nxt[k] = data_q[k];
            endcase
         end
      end
   end

   always_comb begin
      ser_load  = (act == ACT_START) || (act == ACT_COMMA) ||
                  (act == ACT_INS)   || (act == ACT_DATA);
      ser_shift = (act == ACT_SHIFT);
      ser_clear = (act == ACT_END);
      for (int k = 0; k < LANES; k++)
         lane_din[k] = ((act == ACT_DATA) && (mode_q != MODE_COMMA)) ?
                       data_nxt[k] : COMMA;
   end

   always_ff @(posedge clk_8f) begin
      if (reset) begin
         state       <= ST_IDLE;
         mode_q      <= MODE_INC;
         burst_q     <= '0;
         bit_cnt     <= '0;
         sym_cnt     <= '0;
         ins_q       <= 1'b0;
         done_r      <= 1'b0;
         is_comma    <= 1'b0;
         byte_strobe <= 1'b0;
         busy        <= 1'b0;
         for (int k = 0; k < LANES; k++) data_q[k] <= '0;
`ifdef COMMA_INSERT_EN
         gap_cnt     <= '0;
`endif
      end else begin
         if (adv)
            for (int k = 0; k < LANES; k++) data_q[k] <= data_nxt[k];
         case (act)
            ACT_START: begin
               state       <= ST_SYNC;
               mode_q      <= mode_e'(mode);
               burst_q     <= burst_len;
               bit_cnt     <= BIT_LAST;
               sym_cnt     <= 8'(NUM_COMMA - 1);
               ins_q       <= 1'b0;
               is_comma    <= 1'b1;
               byte_strobe <= (WIDTH == 1);
               busy        <= 1'b1;
               for (int k = 0; k < LANES; k++) data_q[k] <= seed - WIDTH'(k);
            end
            ACT_SHIFT: begin
               bit_cnt     <= bit_cnt - 1'b1;
               byte_strobe <= (bit_cnt == BW'(1));
            end
            ACT_COMMA: begin
               bit_cnt     <= BIT_LAST;
               sym_cnt     <= sym_cnt - 8'd1;
               byte_strobe <= (WIDTH == 1);
            end
            ACT_INS: begin
               bit_cnt     <= BIT_LAST;
               sym_cnt     <= sym_cnt - 8'd1;
               ins_q       <= 1'b1;
               is_comma    <= 1'b1;
               byte_strobe <= (WIDTH == 1);
`ifdef COMMA_INSERT_EN
               gap_cnt     <= 8'(GAP - 1);
`endif
            end
            ACT_DATA: begin
               bit_cnt     <= BIT_LAST;
               is_comma    <= (mode_q == MODE_COMMA);
               byte_strobe <= (WIDTH == 1);
               if (state == ST_SYNC) begin
                  state   <= ST_DATA;
                  sym_cnt <= burst_q - 8'd1;
`ifdef COMMA_INSERT_EN
                  gap_cnt <= 8'(GAP - 1);
`endif
               end else if (ins_q) begin
                  // the byte after an inserted comma was already counted
                  ins_q   <= 1'b0;
               end else begin
                  sym_cnt <= sym_cnt - 8'd1;
`ifdef COMMA_INSERT_EN
                  gap_cnt <= gap_cnt - 8'd1;
`endif
               end
            end
            ACT_END: begin
               state       <= ST_DONE;
               bit_cnt     <= '0;
               sym_cnt     <= '0;
               ins_q       <= 1'b0;
               done_r      <= 1'b1;
               is_comma    <= 1'b0;
               byte_strobe <= 1'b0;
               busy        <= 1'b0;
            end
            ACT_FINISH: begin
               state  <= ST_IDLE;
               done_r <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // A pending done stays latched while frozen and is shown once enable returns.
   assign done = done_r & enable;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      lane_serializer #(.WIDTH(WIDTH)) u_ser (
         .clk_8f (clk_8f),
         .reset  (reset),
         .en     (enable),
         .load   (ser_load),
         .shift  (ser_shift),
         .clear  (ser_clear),
         .din    (lane_din[k]),
         .dout   (out[k])
      );
   end

endmodule

// File: tb/tb_phy_tx_pattern_gen.sv
// Bench for phy_tx_pattern_gen. Each sequence's expected per-cycle outputs
// are built from a symbol-level model and queued when start is driven, then
// popped and compared cycle by cycle (held value while enable=0).
module tb_phy_tx_pattern_gen;

   localparam int LANES     = 2;
   localparam int WIDTH     = 8;
   localparam int NUM_COMMA = 4;
   localparam int GAP       = 2;
   localparam logic [7:0] COMMA = 8'hBC;
`ifdef COMMA_INSERT_EN
   localparam logic [7:0] STEP = 8'h01;
`else
   localparam logic [7:0] STEP = 8'h11;
`endif

   typedef logic [LANES-1:0][WIDTH-1:0] lane_vec_t;

   logic             clk_8f    = 1'b0;
   logic             reset     = 1'b1;
   logic             enable    = 1'b1;
   logic             start     = 1'b0;
   logic [1:0]       mode      = 2'd0;
   logic [7:0]       seed      = 8'h00;
   logic [7:0]       burst_len = 8'h00;
   logic [LANES-1:0] out;
   logic             is_comma, byte_strobe, busy, done;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q [$];

   phy_tx_pattern_gen #(
      .LANES(LANES), .WIDTH(WIDTH), .COMMA(COMMA),
      .NUM_COMMA(NUM_COMMA), .STEP(STEP), .GAP(GAP)
   ) dut (
      .clk_8f      (clk_8f),
      .reset       (reset),
      .enable      (enable),
      .start       (start),
      .mode        (mode),
      .seed        (seed),
      .burst_len   (burst_len),
      .out         (out),
      .is_comma    (is_comma),
      .byte_strobe (byte_strobe),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk_8f = ~clk_8f;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] vec(input logic [LANES-1:0] o, input logic c,
                                       input logic s, input logic b, input logic d);
      return 32'({o, c, s, b, d});
   endfunction

   function automatic logic [31:0] obs();
      return vec(out, is_comma, byte_strobe, busy, done);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk_8f);
      #1;
   endtask

   task automatic push_sym(input lane_vec_t v, input logic isc);
      logic [LANES-1:0] o;
      for (int b = WIDTH - 1; b >= 0; b--) begin
         for (int k = 0; k < LANES; k++) o[k] = v[k][b];
         exp_q.push_back(vec(o, isc, (b == 0), 1'b1, 1'b0));
      end
   endtask

   // frz_at > 0: enable is dropped after sample frz_at for frz_len edges.
   task automatic run_seq(input string tag, input logic [1:0] m, input logic [7:0] s,
                          input logic [7:0] bl, input int frz_at, input int frz_len);
      lane_vec_t   v;
      int          syms, n, done_n, strobes, busy_n, limit;
      logic [31:0] e, last;
      logic        en_edge;

      exp_q.delete();
      for (int k = 0; k < LANES; k++) v[k] = COMMA;
      for (int i = 0; i < NUM_COMMA; i++) push_sym(v, 1'b1);
      syms = NUM_COMMA;
      for (int j = 0; j < int'(bl); j++) begin
`ifdef COMMA_INSERT_EN
         if (j > 0 && (j % GAP) == 0) begin
            for (int k = 0; k < LANES; k++) v[k] = COMMA;
            push_sym(v, 1'b1);
            syms++;
         end
`endif
         for (int k = 0; k < LANES; k++) begin
            case (m)
               2'd0:    v[k] = 8'(int'(s) - k + j * int'(STEP));
               2'd1:    v[k] = 8'(int'(s) - k - j * int'(STEP));
               2'd2:    v[k] = 8'(int'(s) - k);
               default: v[k] = COMMA;
            endcase
         end
         push_sym(v, (m == 2'd3));
         syms++;
      end
      exp_q.push_back(vec('0, 1'b0, 1'b0, 1'b0, 1'b1));
      exp_q.push_back(vec('0, 1'b0, 1'b0, 1'b0, 1'b0));

      mode = m; seed = s; burst_len = bl; start = 1'b1;
      n = 0; done_n = 0; strobes = 0; busy_n = 0; last = '0;
      limit = exp_q.size() + frz_len + 4;
      while (exp_q.size() > 0 && n < limit) begin
         en_edge = enable;
         step();
         n++;
         if (n == 2) start = 1'b0;  // start held one extra cycle while busy
         if (en_edge) begin
            e    = exp_q.pop_front();
            last = e;
         end else begin
            e = last & ~32'd1;
         end
         chk(tag, obs(), e);
         if (done && done_n == 0) done_n = n;
         if (en_edge) begin
            strobes += int'(byte_strobe);
            busy_n  += int'(busy);
         end
         if (frz_at > 0 && n == frz_at) enable = 1'b0;
         if (frz_at > 0 && n == frz_at + frz_len) enable = 1'b1;
      end
      if (exp_q.size() != 0) chk({tag, "_timeout"}, exp_q.size(), 0);
      chk({tag, "_done_cyc"}, done_n, syms * WIDTH + 1 + frz_len);
      chk({tag, "_strobes"}, strobes, syms);
      chk({tag, "_busy"}, busy_n, syms * WIDTH);
   endtask

   initial begin
      reset = 1'b1; start = 1'b1; enable = 1'b1;
      repeat (4) begin
         step();
         chk("rst", obs(), '0);
      end
      reset = 1'b0; start = 1'b0;
      step();
      chk("idle", obs(), '0);

      run_seq("dec", 2'd1, 8'hFF, 8'd3, 0, 0);
      run_seq("dec_frz", 2'd1, 8'hFF, 8'd3, 44, 5);

      // reset in the middle of DATA
      mode = 2'd0; seed = 8'h20; burst_len = 8'd5; start = 1'b1;
      step();
      start = 1'b0;
      repeat (40) step();
      chk("mid_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      step();
      chk("mid_rst", obs(), '0);
      reset = 1'b0;
      step();
      chk("mid_idle", obs(), '0);

      run_seq("restart", 2'd0, 8'h20, 8'd2, 0, 0);
      run_seq("zero", 2'd0, 8'h00, 8'd0, 0, 0);
      run_seq("hold", 2'd2, 8'h5A, 8'd2, 0, 0);
      run_seq("conly", 2'd3, 8'h33, 8'd2, 0, 0);
      run_seq("inc_wrap", 2'd0, 8'hF8, 8'd3, 0, 0);
`ifdef COMMA_INSERT_EN
      run_seq("ins", 2'd0, 8'h10, 8'd4, 0, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
